// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-addressed data memory that answers one request at a time from a memory
// controller, with a fixed, parameterised latency between request capture and
// the completion strobe.
//
// Handshake: memory_ready is high exactly while the responder is in READY.
// A request is taken on any rising edge where the responder is READY and
// memory_req_valid=1. The single-cycle memory_ack then follows LATENCY cycles
// after that capture edge. memory_req_valid must only be pulsed while
// memory_ready=1. A pulse at any other time is dropped and sets mem_err.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-low
//   memory_req_valid    one-cycle request strobe
//   memory_req_op       0 = no_mem_op, 1 = load, 2 = store (3 behaves as no_mem_op)
//   memory_req_address  byte address; low byte-offset bits are ignored
//   memory_req_data     store data
//   memory_ready        high while a new request can be accepted
//   memory_ack          one-cycle completion strobe
//   memory_data_return  load data while memory_ack=1, otherwise 0
//   mem_err             sticky: out-of-range index or request while busy
//   o_dbg_state         current FSM state (0 READY, 1 BUSY, 2 ACK)
module data_mem_responder #(
  parameter int DEPTH               = 256,
  parameter int LATENCY             = 3,
  parameter int REG_VAL_WIDTH       = 32,
  parameter int D_MEMORY_ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memory_req_valid,
  input  logic [1:0]                     memory_req_op,
  input  logic [D_MEMORY_ADDR_WIDTH-1:0] memory_req_address,
  input  logic [REG_VAL_WIDTH-1:0]       memory_req_data,
  output logic                           memory_ready,
  output logic                           memory_ack,
  output logic [REG_VAL_WIDTH-1:0]       memory_data_return,
  output logic                           mem_err,
  output logic [1:0]                     o_dbg_state
);

  localparam int OFF = $clog2(REG_VAL_WIDTH / 8);
  localparam int IW  = D_MEMORY_ADDR_WIDTH - OFF;
  localparam int AB  = $clog2(DEPTH);

  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd1;

  localparam logic [1:0] S_READY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [3:0]               r_cnt;
  logic [1:0]               r_op;
  logic [IW-1:0]            r_index;
  logic [REG_VAL_WIDTH-1:0] r_data;
  logic                     r_err;

  logic [IW-1:0]            w_req_index;
  logic                     w_capture;
  logic                     w_in_range;
  logic                     w_we;
  logic                     w_unused_offset;
  logic [REG_VAL_WIDTH-1:0] w_words [DEPTH];

  assign w_req_index     = memory_req_address[D_MEMORY_ADDR_WIDTH-1:OFF];
  // Byte-offset bits carry no meaning for a word memory.
  assign w_unused_offset = ^memory_req_address[OFF-1:0];
  assign w_capture       = (r_state == S_READY) && memory_req_valid;
  // The full index is compared so out-of-range requests never alias onto low words.
  assign w_in_range      = (r_index < IW'(DEPTH));
  // Stores commit on the edge that ends the ACK cycle, before any later capture.
  assign w_we            = (r_state == S_ACK) && (r_op == OP_STORE) && w_in_range;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_READY;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_READY: if (memory_req_valid) w_next_state = (LATENCY == 1) ? S_ACK : S_BUSY;
      S_BUSY:  if (r_cnt == 4'd1)    w_next_state = S_ACK;
      S_ACK:   w_next_state = S_READY;
      default: w_next_state = S_READY;
    endcase
  end

  // Output logic
  always_comb begin
    memory_ready       = (r_state == S_READY);
    memory_ack         = (r_state == S_ACK);
    memory_data_return = '0;
    if ((r_state == S_ACK) && (r_op == OP_LOAD) && w_in_range)
      memory_data_return = w_words[r_index[AB-1:0]];
  end

  assign mem_err     = r_err;
  assign o_dbg_state = r_state;

  // Request capture, latency counter and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_op    <= memory_req_op;
        r_index <= w_req_index;
        r_data  <= memory_req_data;
        r_cnt   <= LAT_M1;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (memory_req_valid && ((r_state != S_READY) || (w_req_index >= IW'(DEPTH))))
        r_err <= 1'b1;
    end
  end

  // Storage: one register per word so every word clears on reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [REG_VAL_WIDTH-1:0] r_word;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  r_word <= '0;
      else if (w_we && (r_index[AB-1:0] == AB'(g))) r_word <= r_data;
    end
    assign w_words[g] = r_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // DUT A: LATENCY=3
  logic        a_valid = 1'b0;
  logic [1:0]  a_op = '0;
  logic [31:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic        a_ready, a_ack, a_err;
  logic [31:0] a_rdata;
  logic [1:0]  a_state;

  // DUT B: LATENCY=1
  logic        b_valid = 1'b0;
  logic [1:0]  b_op = '0;
  logic [31:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic        b_ready, b_ack, b_err;
  logic [31:0] b_rdata;
  logic [1:0]  b_state;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut_a (
    .clk(clk), .reset(reset),
    .memory_req_valid(a_valid), .memory_req_op(a_op),
    .memory_req_address(a_addr), .memory_req_data(a_wdata),
    .memory_ready(a_ready), .memory_ack(a_ack),
    .memory_data_return(a_rdata), .mem_err(a_err), .o_dbg_state(a_state)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .memory_req_valid(b_valid), .memory_req_op(b_op),
    .memory_req_address(b_addr), .memory_req_data(b_wdata),
    .memory_ready(b_ready), .memory_ack(b_ack),
    .memory_data_return(b_rdata), .mem_err(b_err), .o_dbg_state(b_state)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_qa[$];
  logic [31:0] exp_qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (a_ack) begin
      if (exp_qa.size() == 0) chk("a_unexpected_ack", 32'd1, 32'd0);
      else                    chk("a_ack_data", a_rdata, exp_qa.pop_front());
    end else begin
      chk("a_idle_data", a_rdata, 32'd0);
    end
    if (b_ack) begin
      if (exp_qb.size() == 0) chk("b_unexpected_ack", 32'd1, 32'd0);
      else                    chk("b_ack_data", b_rdata, exp_qb.pop_front());
    end else begin
      chk("b_idle_data", b_rdata, 32'd0);
    end
  end

  // driver helpers
  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic ackv(input int sel);
    return (sel == 0) ? a_ack : b_ack;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] op,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      a_valid = v; a_op = op; a_addr = addr; a_wdata = data;
    end else begin
      b_valid = v; b_op = op; b_addr = addr; b_wdata = data;
    end
  endtask

  // Controller-style request: sample ready, strobe valid one cycle later,
  // then check ready/ack cycle by cycle. inject pulses a stray store during
  // the first cycle after capture.
  task automatic req(input int sel, input logic [1:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_data,
                     input int lat, input bit inject);
    int c;
    c = 0;
    @(negedge clk);
    while (!rdy(sel) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!rdy(sel)) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    chk("ready_in_valid_cycle", 32'(rdy(sel)), 32'd1);
    drive(sel, 1'b1, op, addr, data);
    if (sel == 0) exp_qa.push_back(exp_data);
    else          exp_qb.push_back(exp_data);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1 && inject) drive(sel, 1'b1, OP_STORE, 32'h0, 32'hFFFF_FFFF);
      else                  drive(sel, 1'b0, OP_NONE, 32'h0, 32'h0);
      if (k <= lat) begin
        chk("ready_low", 32'(rdy(sel)), 32'd0);
        chk("ack_timing", 32'(ackv(sel)), (k == lat) ? 32'd1 : 32'd0);
      end else begin
        chk("ready_back", 32'(rdy(sel)), 32'd1);
        chk("no_back_to_back_ack", 32'(ackv(sel)), 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{OP_LOAD,  32'h24, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{OP_STORE, 32'h10, 32'hDEADBEEF,  32'h0,         1'b0};
    vecs[2]  = '{OP_LOAD,  32'h10, 32'h0,         32'hDEADBEEF,  1'b0};
    vecs[3]  = '{OP_STORE, 32'h10, 32'h12345678,  32'h0,         1'b0};
    vecs[4]  = '{OP_LOAD,  32'h13, 32'h0,         32'h12345678,  1'b0};
    vecs[5]  = '{OP_STORE, 32'h3C, 32'hCAFEF00D,  32'h0,         1'b0};
    vecs[6]  = '{OP_LOAD,  32'h3E, 32'h0,         32'hCAFEF00D,  1'b0};
    vecs[7]  = '{OP_NONE,  32'h10, 32'h11111111,  32'h0,         1'b0};
    vecs[8]  = '{OP_LOAD,  32'h10, 32'h0,         32'h12345678,  1'b0};
    vecs[9]  = '{OP_STORE, 32'h00, 32'h5A5A5A5A,  32'h0,         1'b0};
    vecs[10] = '{OP_LOAD,  32'h00, 32'h0,         32'h5A5A5A5A,  1'b0};
    vecs[11] = '{OP_LOAD,  32'(DEPTH * 4), 32'h0, 32'h0,         1'b1};
    vecs[12] = '{OP_STORE, 32'(DEPTH * 4), 32'h77777777, 32'h0,  1'b1};
    vecs[13] = '{OP_LOAD,  32'h00, 32'h0,         32'h5A5A5A5A,  1'b1};

    // reset state
    #12;
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_ack", 32'(a_ack), 32'd0);
    chk("rst_data", a_rdata, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_state", 32'(a_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // table-driven vectors on the LATENCY=3 instance
    for (int i = 0; i < 14; i++) begin
      req(0, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_data, 3, 1'b0);
      chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].exp_err));
    end

    // stray request while busy: in-flight op unaffected, error flagged
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    chk("err_cleared_by_reset", 32'(a_err), 32'd0);
    req(0, OP_STORE, 32'h0, 32'h0BADF00D, 32'h0, 3, 1'b0);
    chk("err_before_inject", 32'(a_err), 32'd0);
    req(0, OP_LOAD, 32'h0, 32'h0, 32'h0BADF00D, 3, 1'b1);
    chk("err_after_inject", 32'(a_err), 32'd1);
    req(0, OP_LOAD, 32'h0, 32'h0, 32'h0BADF00D, 3, 1'b0);

    // reset during BUSY of a store: no ack, store dropped
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, OP_STORE, 32'h8, 32'hAAAA5555);
    @(negedge clk);
    drive(0, 1'b0, OP_NONE, 32'h0, 32'h0);
    chk("abort_busy", 32'(a_state), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ready_now", 32'(a_ready), 32'd1);
    chk("abort_no_ack", 32'(a_ack), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    req(0, OP_LOAD, 32'h8, 32'h0, 32'h0, 3, 1'b0);
    chk("abort_err", 32'(a_err), 32'd0);

    // LATENCY=1 back-to-back load / store / load
    req(1, OP_LOAD,  32'h8, 32'h0,        32'h0,        1, 1'b0);
    req(1, OP_STORE, 32'h8, 32'hA5A5F00F, 32'h0,        1, 1'b0);
    req(1, OP_LOAD,  32'h8, 32'h0,        32'hA5A5F00F, 1, 1'b0);
    chk("b_err", 32'(b_err), 32'd0);

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 32'(exp_qa.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
